// File: rtl/mul_issue_buffer_if.sv
// Opcode package and handshake bundle for the multiply issue buffer.
// slave = buffer side, master = issue/multiplier/writeback side.
package mul_pkg;
  typedef enum logic [1:0] {
    MUL_MUL   = 2'd0,
    MUL_MULH  = 2'd1,
    MUL_MULHU = 2'd2
  } mul_opcode_t;
endpackage

interface mul_issue_buffer_if #(
  parameter int TAG_W = 8
);
  import mul_pkg::*;

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  mul_opcode_t       in_opcode;
  logic [31:0]       in_src1;
  logic [31:0]       in_src2;
  logic [TAG_W-1:0]  in_tag;
  logic              mul_valid;
  mul_opcode_t       mul_opcode;
  logic [31:0]       mul_src1;
  logic [31:0]       mul_src2;
  logic [31:0]       mul_result;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic [TAG_W-1:0]  out_tag;
  logic              busy;

  modport slave (
    input  flush, in_valid, in_opcode,
    input  in_src1, in_src2, in_tag,
    input  mul_result, out_ready,
    output in_ready, mul_valid, mul_opcode,
    output mul_src1, mul_src2,
    output out_valid, out_result, out_tag,
    output busy
  );

  modport master (
    output flush, in_valid, in_opcode,
    output in_src1, in_src2, in_tag,
    output mul_result, out_ready,
    input  in_ready, mul_valid, mul_opcode,
    input  mul_src1, mul_src2,
    input  out_valid, out_result, out_tag,
    input  busy
  );
endinterface

// File: rtl/mul_issue_buffer.sv
// Execute-stage wrapper for a 1-cycle pipelined multiplier: issue
// handshake, product capture and a small result FIFO for writeback.
// Ports: clk, reset (sync, active-high), io (mul_issue_buffer_if.slave).
module mul_issue_buffer
  import mul_pkg::*;
#(
  parameter int TAG_W = 8,
  parameter int DEPTH = 2
) (
  input logic             clk,
  input logic             reset,
  mul_issue_buffer_if.slave io
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] LIM = (CW+1)'(DEPTH);

  logic             inflight_q, inflight_d;
  logic [TAG_W-1:0] itag_q, itag_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [PW-1:0]    wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [31:0]      res_q [DEPTH];
  logic [TAG_W-1:0] tagm_q [DEPTH];

  logic             kill;
  logic             fire;
  logic             push;
  logic             pop;
  logic [CW:0]      occ;

  assign kill = reset | io.flush;

  assign io.out_valid  = (cnt_q != '0);
  assign io.out_result = res_q[rd_q];
  assign io.out_tag    = tagm_q[rd_q];
  assign io.busy       = inflight_q | io.out_valid;

  assign pop = io.out_valid & io.out_ready;

  // Slots committed after this edge: stored + in flight - leaving.
  assign occ = {1'b0, cnt_q}
             + {{CW{1'b0}}, inflight_q}
             - {{CW{1'b0}}, pop};

  assign io.in_ready = !kill && (occ < LIM);
  assign fire        = io.in_valid & io.in_ready;
  assign push        = inflight_q & ~kill;

  assign io.mul_valid  = fire;
  assign io.mul_opcode = io.in_opcode;
  assign io.mul_src1   = io.in_src1;
  assign io.mul_src2   = io.in_src2;

  always_comb begin
    inflight_d = fire;
    itag_d     = itag_q;
    rd_d       = rd_q + PW'(pop);
    wr_d       = wr_q + PW'(push);
    cnt_d      = cnt_q + CW'(push) - CW'(pop);
    if (fire) itag_d = io.in_tag;
    if (kill) begin
      inflight_d = 1'b0;
      rd_d       = '0;
      wr_d       = '0;
      cnt_d      = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      itag_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      itag_q     <= itag_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      cnt_q      <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      res_q[wr_q]  <= io.mul_result;
      tagm_q[wr_q] <= itag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !pop)
      assert (cnt_q < CW'(DEPTH))
        else $error("result fifo overflow");
  end

endmodule

// File: tb/tb_mul_issue_buffer.sv
// Directed bench for mul_issue_buffer with a 1-cycle multiplier model.
// Ports: none (top-level bench).
module tb_mul_issue_buffer;
  import mul_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] mres = '0;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mul_issue_buffer_if #(.TAG_W(8)) bus ();

  mul_issue_buffer #(
    .TAG_W(8),
    .DEPTH(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .io(bus)
  );

  assign bus.mul_result = mres;

  function automatic logic [31:0] mul_ref(
    mul_opcode_t op, logic [31:0] a, logic [31:0] b
  );
    logic [63:0] s;
    logic [63:0] u;
    s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    u = {32'b0, a} * {32'b0, b};
    unique case (op)
      MUL_MULH:  return s[63:32];
      MUL_MULHU: return u[63:32];
      default:   return u[31:0];
    endcase
  endfunction

  always @(posedge clk)
    if (bus.mul_valid)
      mres <= mul_ref(bus.mul_opcode, bus.mul_src1, bus.mul_src2);

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(logic v, mul_opcode_t op,
                     logic [31:0] a, logic [31:0] b,
                     logic [7:0] t);
    bus.in_valid  = v;
    bus.in_opcode = op;
    bus.in_src1   = a;
    bus.in_src2   = b;
    bus.in_tag    = t;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, MUL_MUL, 32'd0, 32'd0, 8'd0);
  endtask

  initial begin
    logic [4:0] rdy_exp;
    logic [7:0] nt;
    bus.flush = 1'b0;
    bus.out_ready = 1'b0;
    idle();
    tick();
    tick();
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", bus.in_ready, 1);

    // single op 7*6
    bus.out_ready = 1'b1;
    drv(1'b1, MUL_MUL, 32'd7, 32'd6, 8'd3);
    chk("t1_mul_valid", bus.mul_valid, 1);
    chk("t1_src1", bus.mul_src1, 7);
    chk("t1_src2", bus.mul_src2, 6);
    chk("t1_opc", bus.mul_opcode, MUL_MUL);
    tick();
    idle();
    chk("t1_mv_pulse", bus.mul_valid, 0);
    chk("t1_ov_early", bus.out_valid, 0);
    chk("t1_busy", bus.busy, 1);
    tick();
    chk("t1_ov", bus.out_valid, 1);
    chk("t1_res", bus.out_result, 42);
    chk("t1_tag", bus.out_tag, 3);
    tick();
    chk("t1_ov_done", bus.out_valid, 0);
    chk("t1_busy_done", bus.busy, 0);

    // MULH then MULHU back to back
    drv(1'b1, MUL_MULH, 32'hFFFF_FFFF, 32'd2, 8'd10);
    tick();
    drv(1'b1, MUL_MULHU, 32'hFFFF_FFFF, 32'd2, 8'd11);
    chk("t2_ready2", bus.in_ready, 1);
    tick();
    idle();
    chk("t2_ov0", bus.out_valid, 1);
    chk("t2_res0", bus.out_result, 32'hFFFF_FFFF);
    chk("t2_tag0", bus.out_tag, 10);
    tick();
    chk("t2_ov1", bus.out_valid, 1);
    chk("t2_res1", bus.out_result, 32'h1);
    chk("t2_tag1", bus.out_tag, 11);
    tick();
    chk("t2_empty", bus.out_valid, 0);

    // stream of 8 at full rate
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        drv(1'b1, MUL_MUL, i, 32'd3, 8'(i));
        chk("t3_ready", bus.in_ready, 1);
      end else begin
        idle();
      end
      if (i >= 2) begin
        chk("t3_ov", bus.out_valid, 1);
        chk("t3_tag", bus.out_tag, i - 2);
        chk("t3_res", bus.out_result, (i - 2) * 3);
      end
      tick();
    end
    chk("t3_empty", bus.out_valid, 0);

    // backpressure: exactly DEPTH accepted
    bus.out_ready = 1'b0;
    rdy_exp = 5'b00011;
    nt = 8'd20;
    for (int i = 0; i < 5; i++) begin
      drv(1'b1, MUL_MUL, 32'(nt), 32'd2, nt);
      chk("t4_ready", bus.in_ready, rdy_exp[i]);
      chk("t4_mv", bus.mul_valid, rdy_exp[i]);
      if (rdy_exp[i]) nt++;
      tick();
    end
    bus.out_ready = 1'b1;
    drv(1'b1, MUL_MUL, 32'd22, 32'd2, 8'd22);
    chk("t4_resume", bus.in_ready, 1);
    chk("t4_tagA", bus.out_tag, 20);
    chk("t4_resA", bus.out_result, 40);
    tick();
    drv(1'b1, MUL_MUL, 32'd23, 32'd2, 8'd23);
    chk("t4_ready_b", bus.in_ready, 1);
    chk("t4_tagB", bus.out_tag, 21);
    tick();
    idle();
    chk("t4_tagC", bus.out_tag, 22);
    tick();
    chk("t4_tagD", bus.out_tag, 23);
    chk("t4_resD", bus.out_result, 46);
    tick();
    chk("t4_empty", bus.out_valid, 0);

    // flush with one entry queued and one in flight
    bus.out_ready = 1'b0;
    drv(1'b1, MUL_MUL, 32'd5, 32'd5, 8'd40);
    tick();
    idle();
    tick();
    drv(1'b1, MUL_MUL, 32'd9, 32'd9, 8'd41);
    chk("t5_ov_pre", bus.out_valid, 1);
    tick();
    bus.flush = 1'b1;
    drv(1'b1, MUL_MUL, 32'd1, 32'd1, 8'd50);
    chk("t5_fl_ready", bus.in_ready, 0);
    chk("t5_fl_mv", bus.mul_valid, 0);
    tick();
    bus.flush = 1'b0;
    idle();
    chk("t5_ov", bus.out_valid, 0);
    chk("t5_busy", bus.busy, 0);
    bus.out_ready = 1'b1;
    drv(1'b1, MUL_MUL, 32'd4, 32'd5, 8'd42);
    chk("t5_mv_next", bus.mul_valid, 1);
    tick();
    idle();
    tick();
    chk("t5_ov_next", bus.out_valid, 1);
    chk("t5_tag_next", bus.out_tag, 42);
    chk("t5_res_next", bus.out_result, 20);
    tick();
    chk("t5_no_ghost", bus.out_valid, 0);

    // reset with occupancy full and an op in flight
    bus.out_ready = 1'b0;
    drv(1'b1, MUL_MUL, 32'd2, 32'd3, 8'd60);
    tick();
    drv(1'b1, MUL_MUL, 32'd3, 32'd3, 8'd61);
    tick();
    drv(1'b1, MUL_MUL, 32'd4, 32'd4, 8'd62);
    chk("t6_full", bus.in_ready, 0);
    chk("t6_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("t6_rst_ready", bus.in_ready, 0);
    tick();
    chk("t6_ov", bus.out_valid, 0);
    chk("t6_busy0", bus.busy, 0);
    chk("t6_ready_hi", bus.in_ready, 0);
    reset = 1'b0;
    #1;
    chk("t6_ready", bus.in_ready, 1);
    bus.out_ready = 1'b1;
    tick();
    idle();
    tick();
    chk("t6_tag", bus.out_tag, 62);
    chk("t6_res", bus.out_result, 16);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_issue_buffer.md
Name: mul_issue_buffer

Overview:
- Execute-stage control wrapper around the pipelined multiplier, which has one cycle of latency and a clock-enable input.
- Accepts multiply requests from issue with a valid/ready handshake and drives the multiplier's valid (CE), opcode and operand inputs.
- Captures the product exactly one cycle after issue and queues it with its tag in a small FIFO for writeback, which may backpressure.
- Handles pipeline flush.

Parameters:
TAG_W, 8, width of the opaque tag carried with each op (rd index, ROB id, etc.)
DEPTH, 2, result FIFO entries; power of two, >= 2

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
flush  input  1  discard all accepted and in-flight ops this cycle
in_valid  input  1  issue offers an op
in_ready  output  1  block can accept this cycle
in_opcode  input  mul_opcode_t  MUL_MUL / MUL_MULH / MUL_MULHU
in_src1  input  32  operand A
in_src2  input  32  operand B
in_tag  input  TAG_W  tag returned with result
mul_valid  output  1  to multiplier valid (CE)
mul_opcode  output  mul_opcode_t  to multiplier opcode
mul_src1  output  32  to multiplier src1
mul_src2  output  32  to multiplier src2
mul_result  input  32  multiplier result, valid the cycle after mul_valid
out_valid  output  1  FIFO head valid
out_ready  input  1  writeback consumes head
out_result  output  32  head result
out_tag  output  TAG_W  head tag
busy  output  1  inflight or FIFO non-empty

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- State: inflight bit, inflight_tag register, FIFO (rd ptr, wr ptr, count of log2(DEPTH)+1 bits).
- Reset: inflight=0, count=0, ptrs=0. Consequently out_valid=0 and busy=0. in_ready=0 while reset is high.
- Operand paths: mul_opcode, mul_src1 and mul_src2 are combinational pass-throughs of in_opcode, in_src1 and in_src2, every cycle. The multiplier latches its opcode every cycle, so the opcode presented in the issue cycle selects the result half.
- pop = out_valid & out_ready.
- in_ready = !reset & !flush & (count + inflight - pop < DEPTH). This gives a combinational path out_ready -> in_ready, which is permitted.
- Issue: fire = in_valid & in_ready. mul_valid = fire, so the multiplier CE is 0 on idle, stall and flush cycles. On fire: inflight<=1, inflight_tag<=in_tag. Otherwise inflight<=0.
- Capture: in the cycle after fire (inflight=1, no flush), push {mul_result, inflight_tag} at wr ptr. Latency is issue to out_valid = 2 cycles, i.e. visible the cycle after capture.
- Throughput: 1 op/cycle sustained when out_ready is held high.
- Simultaneous push and pop: count is unchanged and both pointers advance. Pointers wrap mod DEPTH.
- Full: count=DEPTH forces in_ready=0. count=DEPTH-1 with inflight=1 and no pop also forces in_ready=0. The FIFO never overflows, and an assertion checks this.
- Empty: out_valid=0. out_result and out_tag are don't-care. A pop is ignored.
- flush (priority over everything):
  - inflight<=0, count<=0, ptrs<=0, with no capture that cycle.
  - in_ready=0 and mul_valid=0 that cycle.
  - A pop in the flush cycle is still reported to writeback if out_valid was 1; writeback discards it as it is flushing too.
- reset mid-operation: identical to flush; all state is cleared on the next edge.
- out_valid, out_result and out_tag come from registers or FIFO storage, with no combinational path from in_*.

Test Plan:
- Reset, then a single op MUL_MUL, src1=7, src2=6, tag=3, out_ready=1: mul_valid pulses 1 cycle; out_valid rises 2 cycles after issue with out_result=42, out_tag=3; busy returns to 0.
- MUL_MULH 0xFFFFFFFF*0x00000002 -> 0xFFFFFFFF. MUL_MULHU same operands -> 0x00000001. Issued back-to-back, results returned in order with correct tags.
- Stream of 8 ops, out_ready=1 constantly: in_ready stays 1, one result per cycle, tags 0..7 in order.
- out_ready=0 with in_valid=1 continuous: exactly DEPTH ops accepted, then in_ready=0 and mul_valid=0. Raising out_ready drains them in order and acceptance resumes the same cycle as the first pop.
- flush asserted in the cycle after an issue with the FIFO holding one entry: next cycle out_valid=0, busy=0; the in-flight product is never output; the next op issues normally.
- Reset asserted with the FIFO full and an op in flight: after one edge out_valid=0, busy=0, and in_ready=1 once reset drops.
